// File: rtl/stack_pkg.sv
// Shared definitions for the operand stack.
//   WIDTH_DEF / DEPTH_DEF : default data width and entry count
//   SRC_ALU / SRC_MEM     : push-source select values for MtoS
//   cmd_e / decode_cmd    : one-hot decode of push/pop/tos into a command
package stack_pkg;
    localparam int WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 8;

    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_MEM = 1'b1;

    typedef enum logic [2:0] {
        CMD_IDLE,
        CMD_PUSH,
        CMD_POP,
        CMD_TOS,
        CMD_MULTI   // more than one request in the same cycle
    } cmd_e;

    function automatic cmd_e decode_cmd(input logic push, input logic pop, input logic tos);
        case ({push, pop, tos})
            3'b000:  return CMD_IDLE;
            3'b100:  return CMD_PUSH;
            3'b010:  return CMD_POP;
            3'b001:  return CMD_TOS;
            default: return CMD_MULTI;
        endcase
    endfunction
endpackage

// File: rtl/operand_stack_if.sv
// Command/status bundle of the operand stack.
//   master : drives push/pop/tos/MtoS/mem_data/alu_res/clr_err, observes status
//   slave  : the stack itself; drives d_out/count/empty/full/ovf/unf/err
interface operand_stack_if #(
    parameter int WIDTH = stack_pkg::WIDTH_DEF,
    parameter int DEPTH = stack_pkg::DEPTH_DEF
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             push;
    logic             pop;
    logic             tos;
    logic             MtoS;
    logic [WIDTH-1:0] mem_data;
    logic [WIDTH-1:0] alu_res;
    logic             clr_err;
    logic [WIDTH-1:0] d_out;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             ovf;
    logic             unf;
    logic             err;

    modport master (
        output push, pop, tos, MtoS, mem_data, alu_res, clr_err,
        input  d_out, count, empty, full, ovf, unf, err
    );

    modport slave (
        input  push, pop, tos, MtoS, mem_data, alu_res, clr_err,
        output d_out, count, empty, full, ovf, unf, err
    );
endinterface

// File: rtl/stack_mem.sv
// Stack storage: DEPTH x WIDTH register array, no reset.
//   clk         : write clock
//   we/waddr/wdata : synchronous write port
//   raddr/rdata : combinational read port
module stack_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/operand_stack.sv
// Operand stack: push/pop/tos with saturating count, registered d_out and
// sticky ovf/unf/err flags.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : operand_stack_if.slave (commands in, status/data out)
module operand_stack
    import stack_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    operand_stack_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    cmd_e             cmd;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] d_out_q;
    logic             ovf_q, unf_q, err_q;
    logic             empty, full;
    logic             wr_en;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] wr_data, rd_data;

    assign cmd   = decode_cmd(bus.push, bus.pop, bus.tos);
    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(DEPTH));

    assign wr_en   = (cmd == CMD_PUSH) && !full;
    assign wr_data = (bus.MtoS == SRC_MEM) ? bus.mem_data : bus.alu_res;
    // Top entry is cnt-1; the low bits wrap correctly even when cnt == DEPTH.
    assign rd_addr = cnt[AW-1:0] - AW'(1);

    stack_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (cnt[AW-1:0]),
        .wdata (wr_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // Flag sets are written after the clear so a same-cycle event wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            d_out_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (bus.clr_err) begin
                ovf_q <= 1'b0;
                unf_q <= 1'b0;
                err_q <= 1'b0;
            end
            case (cmd)
                CMD_PUSH: begin
                    if (full) ovf_q <= 1'b1;
                    else      cnt   <= cnt + CW'(1);
                end
                CMD_POP: begin
                    if (empty) unf_q <= 1'b1;
                    else begin
                        d_out_q <= rd_data;
                        cnt     <= cnt - CW'(1);
                    end
                end
                CMD_TOS: begin
                    if (empty) unf_q   <= 1'b1;
                    else       d_out_q <= rd_data;
                end
                CMD_MULTI: err_q <= 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.d_out = d_out_q;
    assign bus.count = cnt;
    assign bus.empty = empty;
    assign bus.full  = full;
    assign bus.ovf   = ovf_q;
    assign bus.unf   = unf_q;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_operand_stack.sv
// Directed self-checking bench for operand_stack (WIDTH=8, DEPTH=8).
module tb_operand_stack;
    import stack_pkg::*;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    operand_stack_if #(.WIDTH(8), .DEPTH(8)) bus ();

    operand_stack #(.WIDTH(8), .DEPTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.push     = 1'b0;
        bus.pop      = 1'b0;
        bus.tos      = 1'b0;
        bus.MtoS     = 1'b0;
        bus.clr_err  = 1'b0;
        bus.mem_data = 8'h00;
        bus.alu_res  = 8'h00;
    endtask

    // Drive one cycle of inputs, clock it, return 1 time unit after the edge.
    task automatic step(input logic p, input logic po, input logic t, input logic m,
                        input logic [7:0] md, input logic [7:0] ar, input logic ce);
        bus.push     = p;
        bus.pop      = po;
        bus.tos      = t;
        bus.MtoS     = m;
        bus.mem_data = md;
        bus.alu_res  = ar;
        bus.clr_err  = ce;
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic push_alu(input logic [7:0] v); step(1, 0, 0, SRC_ALU, 8'hEE, v, 0); endtask
    task automatic push_mem(input logic [7:0] v); step(1, 0, 0, SRC_MEM, v, 8'h99, 0); endtask
    task automatic do_pop();                    step(0, 1, 0, 0, 8'h00, 8'h00, 0); endtask
    task automatic do_tos();                    step(0, 0, 1, 0, 8'h00, 8'h00, 0); endtask
    task automatic do_clr();                    step(0, 0, 0, 0, 8'h00, 8'h00, 1); endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tests = 0;
        fails = 0;
        idle_inputs();
        rst_n = 1'b0;
        #12;
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_dout",  32'(bus.d_out), 0);
        chk("rst_empty", 32'(bus.empty), 1);
        chk("rst_full",  32'(bus.full),  0);
        chk("rst_flags", 32'({bus.ovf, bus.unf, bus.err}), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Source select and LIFO order
        push_alu(8'h11);
        push_mem(8'h22);
        chk("two_push_count", 32'(bus.count), 2);
        do_pop();
        chk("pop1_dout",  32'(bus.d_out), 32'h22);
        chk("pop1_count", 32'(bus.count), 1);
        do_pop();
        chk("pop2_dout",  32'(bus.d_out), 32'h11);
        chk("pop2_empty", 32'(bus.empty), 1);

        // Fill to DEPTH, overflow, drain
        for (int i = 1; i <= 8; i++) push_alu(8'(i));
        chk("fill_full",  32'(bus.full),  1);
        chk("fill_count", 32'(bus.count), 8);
        chk("fill_ovf",   32'(bus.ovf),   0);
        push_alu(8'h09);
        chk("ovf_flag",  32'(bus.ovf),   1);
        chk("ovf_count", 32'(bus.count), 8);
        chk("ovf_dout",  32'(bus.d_out), 32'h11);
        for (int i = 8; i >= 1; i--) begin
            do_pop();
            chk($sformatf("drain_%0d", i), 32'(bus.d_out), 32'(i));
        end
        chk("drain_empty", 32'(bus.empty), 1);
        chk("ovf_sticky",  32'(bus.ovf),   1);
        do_clr();
        chk("ovf_clr", 32'(bus.ovf), 0);

        // Underflow
        do_pop();
        chk("unf_flag",  32'(bus.unf),   1);
        chk("unf_dout",  32'(bus.d_out), 32'h01);
        chk("unf_count", 32'(bus.count), 0);
        do_clr();
        chk("unf_clr", 32'(bus.unf), 0);

        // TOS and illegal combination
        push_alu(8'h5A);
        do_tos();
        chk("tos1_dout",  32'(bus.d_out), 32'h5A);
        chk("tos1_count", 32'(bus.count), 1);
        do_tos();
        chk("tos2_dout",  32'(bus.d_out), 32'h5A);
        chk("tos2_count", 32'(bus.count), 1);
        step(1, 1, 0, SRC_MEM, 8'h77, 8'h66, 0);
        chk("multi_err",   32'(bus.err),   1);
        chk("multi_count", 32'(bus.count), 1);
        chk("multi_dout",  32'(bus.d_out), 32'h5A);
        do_clr();
        chk("err_clr", 32'(bus.err), 0);

        // Push right after pop reuses the slot, no bubble
        push_mem(8'h10);
        do_pop();
        chk("reuse_pop", 32'(bus.d_out), 32'h10);
        push_alu(8'h20);
        do_tos();
        chk("reuse_tos",   32'(bus.d_out), 32'h20);
        chk("reuse_count", 32'(bus.count), 2);

        // Asynchronous reset mid-cycle
        push_alu(8'h33);
        do_tos();
        chk("pre_rst_dout", 32'(bus.d_out), 32'h33);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_count", 32'(bus.count), 0);
        chk("async_dout",  32'(bus.d_out), 0);
        chk("async_empty", 32'(bus.empty), 1);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_alu(8'h44);
        chk("post_rst_count", 32'(bus.count), 1);
        do_tos();
        chk("post_rst_tos", 32'(bus.d_out), 32'h44);

        // Flag set beats clear in the same cycle
        do_pop();
        chk("last_pop", 32'(bus.d_out), 32'h44);
        step(0, 1, 0, 0, 8'h00, 8'h00, 1);
        chk("unf_priority", 32'(bus.unf),   1);
        chk("unf_pri_dout", 32'(bus.d_out), 32'h44);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
